bounce_gen: RTL
===============

BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 SHALL have parameter NBOUNCE, default 2: number of extra toggle pairs per transition (range 1..15).
REQ-002 SHALL have parameter GAPW, default 3: LFSR bits used for inter-toggle gap (range 1..7).
REQ-003 SHALL have parameter HOLD, default 8: stable cycles after the final toggle before done (range 1..255).
REQ-004 SHALL have parameter SEED, default 8'hA5: LFSR reset value (nonzero required).
REQ-005 SHALL have port clkDiv190  in  1  clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  in  1  one-cycle transition request, sampled each clock edge.
REQ-008 SHALL have port level  in  1  target settled level, sampled with start.
REQ-009 SHALL have port dout  out  1  emulated bouncing switch output, registered.
REQ-010 SHALL have port busy  out  1  high while a transition is in progress, registered.
REQ-011 SHALL have port done  out  1  one-cycle pulse when a request completes, registered.

Function
REQ-012 SHALL implement an FSM with states IDLE, BOUNCE, SETTLE; busy = 1 exactly in BOUNCE and SETTLE.
REQ-013 SHALL run an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, advancing every cycle in every state.
REQ-014 IDLE, start=1, level!=dout: same edge toggles dout, latches target, loads toggle counter with 2*NBOUNCE, loads gap counter with G=1+lfsr[GAPW-1:0], enters BOUNCE.
REQ-015 IDLE, start=1, level==dout: no dout change, stays IDLE, done=1 on the following cycle only.
REQ-016 BOUNCE: gap counter decrements each cycle; consecutive dout toggles are exactly G cycles apart, G taken from the LFSR value at the previous toggle edge (1..2^GAPW).
REQ-017 BOUNCE: each toggle decrements the toggle counter; the toggle that brings it to 0 enters SETTLE with hold counter = HOLD.
REQ-018 Total toggles per transition SHALL be 2*NBOUNCE+1; final dout SHALL equal the latched target.
REQ-019 SETTLE: dout constant; after HOLD cycles enter IDLE with done=1 for one cycle, busy=0 in that same cycle.
REQ-020 start while busy=1 SHALL be ignored: no latch, no counter or dout effect, no extra done.
REQ-021 start in the done cycle SHALL be accepted as a fresh IDLE request.
REQ-022 level changes while busy SHALL have no effect.
REQ-023 Counters SHALL never wrap: gap and hold counters stop at their terminal value and the state transition consumes it.

Reset
REQ-024 rst=1 SHALL immediately force dout=0, busy=0, done=0, state IDLE, all counters 0, LFSR=SEED.
REQ-025 rst asserted mid-BOUNCE or mid-SETTLE SHALL abort the transition with no done pulse; first start after release behaves per REQ-014/015.
REQ-026 Post-reset sequences SHALL be deterministic: identical stimulus from reset gives identical dout waveforms.

Verification (NBOUNCE=2, GAPW=3, HOLD=8, SEED=8'hA5)
REQ-027 Assert rst asynchronously between edges -> dout=0, busy=0, done=0 before the next edge; LFSR reads 8'hA5.
REQ-028 From reset, start=1 and level=1 for one cycle -> exactly 5 dout toggles, final dout=1, each gap 1..8 and matching a software LFSR model, 8 stable cycles, then a single done pulse with busy falling in the same cycle.
REQ-029 From reset, start=1 and level=0 -> zero toggles, busy stays 0, done=1 exactly one cycle later.
REQ-030 Second start (level=0) pulsed mid-BOUNCE of a 0->1 transition -> ignored; still 5 toggles, final 1, single done.
REQ-031 rst pulsed two cycles after entering SETTLE -> dout=0, busy=0, no done; then start with level=1 -> full 5-toggle sequence.
REQ-032 Back-to-back: start with level=0 in the done cycle of a 0->1 transition -> accepted, 5 toggles, final dout=0, second done.

Source files
------------

// File: rtl/bounce_gen.sv
// Emulates a mechanically bouncing switch: each accepted level change toggles
// dout an odd number of times with pseudo-random gaps, holds, then pulses done.
module bounce_gen #(
   parameter int         NBOUNCE = 2,
   parameter int         GAPW    = 3,
   parameter int         HOLD    = 8,
   parameter logic [7:0] SEED    = 8'hA5
) (
   input  logic clkDiv190,
   input  logic rst,
   input  logic start,
   input  logic level,
   output logic dout,
   output logic busy,
   output logic done
);

   localparam int TOGW = 5;
   localparam int GW   = GAPW + 1;

   localparam logic [TOGW-1:0] TOG_LOAD  = TOGW'(2 * NBOUNCE);
   localparam logic [7:0]      HOLD_LOAD = 8'(HOLD);

   typedef enum logic [1:0] {
      IDLE,
      BOUNCE,
      SETTLE
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      lfsr_q, lfsr_d;
   logic            dout_q, dout_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            target_q, target_d;
   logic [TOGW-1:0] tog_q, tog_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [7:0]      hold_q, hold_d;
   logic [GW-1:0]   gap_load;

   // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1; the LFSR free-runs in every state.
   assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign gap_load = {1'b0, lfsr_q[GAPW-1:0]} + GW'(1);

   always_ff @(posedge clkDiv190 or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         lfsr_q   <= SEED;
         dout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         target_q <= 1'b0;
         tog_q    <= '0;
         gap_q    <= '0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         dout_q   <= dout_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         target_q <= target_d;
         tog_q    <= tog_d;
         gap_q    <= gap_d;
         hold_q   <= hold_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      dout_d   = dout_q;
      target_d = target_q;
      tog_d    = tog_q;
      gap_d    = gap_q;
      hold_d   = hold_q;
      done_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (level != dout_q) begin
                  dout_d   = ~dout_q;
                  target_d = level;
                  tog_d    = TOG_LOAD;
                  gap_d    = gap_load;
                  state_d  = BOUNCE;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         BOUNCE: begin
            // Terminal gap value is consumed by the toggle, never decremented past.
            if (gap_q <= GW'(1)) begin
               if (tog_q <= TOGW'(1)) begin
                  dout_d  = target_q;
                  tog_d   = '0;
                  gap_d   = '0;
                  hold_d  = HOLD_LOAD;
                  state_d = SETTLE;
               end else begin
                  dout_d = ~dout_q;
                  tog_d  = tog_q - TOGW'(1);
                  gap_d  = gap_load;
               end
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end

         SETTLE: begin
            if (hold_q <= 8'd1) begin
               hold_d  = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               hold_d = hold_q - 8'd1;
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign dout = dout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
